register_file: RTL

- Architectural 32 x 32-bit MIPS general-purpose register file.
- Sits directly upstream of the read-port multiplexing: its 32 register outputs form the data inputs selected by ReadRegister, and it is written from the write-back stage.
- One synchronous write port and two combinational read ports.
- $zero is hardwired, and write-to-read bypass is optional within the same cycle.

---
 rtl/mips_pkg.sv | 14 +
 rtl/regfile_read_port.sv | 31 +++
 rtl/register_file.sv | 66 ++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types for the architectural register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: $zero forcing, optional same-cycle write forwarding, stored-value mux.
// Latency: zero cycles (pure combinational).
// Backpressure: none; always produces a value.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int BYPASS     = 1
) (
    input  logic [ADDR_WIDTH-1:0]                         index,
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]      regs,
    input  logic                                          wr_en,
    input  logic [ADDR_WIDTH-1:0]                         wr_addr,
    input  logic [DATA_WIDTH-1:0]                         wr_data,
    output logic [DATA_WIDTH-1:0]                         data
);

    // Index 0 always reads zero; otherwise a live matching write wins over storage when forwarding is built in.
    always_comb begin
        data = '0;
        if (index != '0) begin
            if ((BYPASS != 0) && wr_en && (wr_addr == index)) begin
                data = wr_data;
            end else begin
                data = regs[index];
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit MIPS GPR file: one synchronous write port, two combinational read ports, hardwired $zero.
// Latency: reads zero cycles; writes visible next cycle, or same cycle on matching read ports when BYPASS=1.
// Backpressure: none; a write is accepted on every enabled edge.
module register_file
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    // Entry 0 is cleared by reset and never written, but read ports never consult it anyway.
    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;

    // A write in a reset cycle is dropped, so it must not be forwarded either.
    logic wr_live;
    assign wr_live = RegWrite && !reset;

    // Storage update: reset clears everything and overrides any pending write; writes to index 0 are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
        end else if (RegWrite && (WriteRegister != '0)) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS)
    ) u_rd1 (
        .index   (ReadRegister1),
        .regs    (regs),
        .wr_en   (wr_live),
        .wr_addr (WriteRegister),
        .wr_data (WriteData),
        .data    (ReadData1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS)
    ) u_rd2 (
        .index   (ReadRegister2),
        .regs    (regs),
        .wr_en   (wr_live),
        .wr_addr (WriteRegister),
        .wr_data (WriteData),
        .data    (ReadData2)
    );

endmodule
